// File: rtl/spi_csr_pkg.sv
// rtl/spi_csr_pkg.sv - register map, bit positions and IRQ indices for spi_csr
package spi_csr_pkg;

  // Register offsets on the local CSR bus
  localparam logic [31:0] CSR_CTRL     = 32'h0000_0000;
  localparam logic [31:0] CSR_STAT     = 32'h0000_0004;
  localparam logic [31:0] CSR_TXDATA   = 32'h0000_0008;
  localparam logic [31:0] CSR_RXDATA   = 32'h0000_000C;
  localparam logic [31:0] CSR_IRQ_STAT = 32'h0000_0010;
  localparam logic [31:0] CSR_IRQ_EN   = 32'h0000_0014;

  // CTRL bit positions
  localparam int CTRL_SPI_EN      = 0;
  localparam int CTRL_MASTER_EN   = 1;
  localparam int CTRL_CPOL        = 2;
  localparam int CTRL_CPHA        = 3;
  localparam int CTRL_LSB_FIRST   = 4;
  localparam int CTRL_TX_FLUSH    = 5;
  localparam int CTRL_RX_FLUSH    = 6;
  localparam int CTRL_CLK_DIV_LSB = 8;
  localparam int CTRL_CS_LSB      = 16;

  // STAT bit positions
  localparam int STAT_TX_FULL      = 0;
  localparam int STAT_TX_EMPTY     = 1;
  localparam int STAT_RX_FULL      = 2;
  localparam int STAT_RX_EMPTY     = 3;
  localparam int STAT_BUSY         = 4;
  localparam int STAT_TX_LEVEL_LSB = 8;
  localparam int STAT_RX_LEVEL_LSB = 16;

  // Interrupt flag indices within IRQ_STAT / IRQ_EN
  localparam int IRQ_W = 3;
  typedef enum logic [1:0] {
    IRQ_DONE     = 2'd0,
    IRQ_RX_OVF   = 2'd1,
    IRQ_TX_EMPTY = 2'd2
  } irq_idx_e;

endpackage

// File: rtl/spi_csr_fifo.sv
// rtl/spi_csr_fifo.sv - synchronous FIFO with flush, level count and zeroed head when empty
module spi_csr_fifo
  import spi_csr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DATA_W-1:0]        head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // A zero head when empty keeps the stream data and RXDATA reads at 0
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array; pointers alone define validity, so no reset is needed here
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and level; flush overrides any push or pop in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        level <= level + LW'(1);
      end else if (!do_push && do_pop) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_csr.sv
// rtl/spi_csr.sv - SPI register block with TX/RX FIFOs; SPI_CSR_IRQ_EN enables IRQ_STAT/IRQ_EN/irq
module spi_csr
  import spi_csr_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CS_W       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       waddr,
  input  logic [31:0]       wdata,
  input  logic              wen,
  input  logic [3:0]        wstrb,
  output logic              wready,
  input  logic [31:0]       raddr,
  input  logic              ren,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              spi_en_out,
  output logic              master_en_out,
  output logic              cpol_out,
  output logic              cpha_out,
  output logic              lsb_first_out,
  output logic [7:0]        clk_div_out,
  output logic [CS_W-1:0]   cs_out,
  output logic [DATA_W-1:0] tx_data_out,
  output logic              tx_valid_out,
  input  logic              tx_ready_in,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic              rx_valid_in,
  input  logic              xfer_done_in,
  input  logic              busy_in,
  output logic              irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0]   tx_level, rx_level;
  logic [DATA_W-1:0] rx_head;
  logic            tx_push, tx_pop, tx_flush;
  logic            rx_pop, rx_flush;
  logic            wr_ok, wr_ctrl;
  logic            busy_q;
  logic [31:0]     ctrl_rd, stat_rd, rd_mux;
  logic            unused_in;

  // A TXDATA write to a full FIFO is the only write that stalls
  assign wready   = !(wen && (waddr == CSR_TXDATA) && tx_full);
  assign wr_ok    = wen && wready;
  assign wr_ctrl  = wr_ok && (waddr == CSR_CTRL);
  assign tx_push  = wr_ok && (waddr == CSR_TXDATA);
  assign tx_pop   = tx_valid_out && tx_ready_in;
  assign tx_flush = wr_ctrl && wstrb[0] && wdata[CTRL_TX_FLUSH];
  assign rx_flush = wr_ctrl && wstrb[0] && wdata[CTRL_RX_FLUSH];
  assign rx_pop   = ren && (raddr == CSR_RXDATA);
  assign tx_valid_out = !tx_empty;

  spi_csr_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (wdata[DATA_W-1:0]),
    .pop       (tx_pop),
    .flush     (tx_flush),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level),
    .head      (tx_data_out)
  );

  // RX has no backpressure: a word arriving while full is dropped inside the FIFO
  spi_csr_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid_in),
    .push_data (rx_data_in),
    .pop       (rx_pop),
    .flush     (rx_flush),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level),
    .head      (rx_head)
  );

  // CTRL fields, each byte lane gated by its strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_en_out    <= 1'b0;
      master_en_out <= 1'b0;
      cpol_out      <= 1'b0;
      cpha_out      <= 1'b0;
      lsb_first_out <= 1'b0;
      clk_div_out   <= '0;
      cs_out        <= '0;
    end else if (wr_ctrl) begin
      if (wstrb[0]) begin
        spi_en_out    <= wdata[CTRL_SPI_EN];
        master_en_out <= wdata[CTRL_MASTER_EN];
        cpol_out      <= wdata[CTRL_CPOL];
        cpha_out      <= wdata[CTRL_CPHA];
        lsb_first_out <= wdata[CTRL_LSB_FIRST];
      end
      if (wstrb[1]) clk_div_out <= wdata[CTRL_CLK_DIV_LSB +: 8];
      if (wstrb[2]) cs_out      <= wdata[CTRL_CS_LSB +: CS_W];
    end
  end

  // Engine busy is sampled once so STAT.BUSY lags by a cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= 1'b0;
    else      busy_q <= busy_in;
  end

  // CTRL and STAT read views; flush bits always read back 0
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_SPI_EN]    = spi_en_out;
    ctrl_rd[CTRL_MASTER_EN] = master_en_out;
    ctrl_rd[CTRL_CPOL]      = cpol_out;
    ctrl_rd[CTRL_CPHA]      = cpha_out;
    ctrl_rd[CTRL_LSB_FIRST] = lsb_first_out;
    ctrl_rd[CTRL_CLK_DIV_LSB +: 8]  = clk_div_out;
    ctrl_rd[CTRL_CS_LSB +: CS_W]    = cs_out;
    stat_rd = '0;
    stat_rd[STAT_TX_FULL]  = tx_full;
    stat_rd[STAT_TX_EMPTY] = tx_empty;
    stat_rd[STAT_RX_FULL]  = rx_full;
    stat_rd[STAT_RX_EMPTY] = rx_empty;
    stat_rd[STAT_BUSY]     = busy_q;
    stat_rd[STAT_TX_LEVEL_LSB +: 8] = 8'(tx_level);
    stat_rd[STAT_RX_LEVEL_LSB +: 8] = 8'(rx_level);
  end

`ifdef SPI_CSR_IRQ_EN
  logic [IRQ_W-1:0] irq_stat, irq_en, irq_set, irq_clr;
  logic             tx_empty_ev;

  // Only a 1->0 level step counts; flushing several entries does not
  assign tx_empty_ev = (tx_level == LW'(1)) && ((tx_pop && !tx_push) || tx_flush);

  // Event sources and W1C mask for the sticky flags
  always_comb begin
    irq_set = '0;
    irq_set[IRQ_DONE]     = xfer_done_in;
    irq_set[IRQ_RX_OVF]   = rx_valid_in && rx_full;
    irq_set[IRQ_TX_EMPTY] = tx_empty_ev;
    irq_clr = '0;
    if (wr_ok && (waddr == CSR_IRQ_STAT) && wstrb[0]) irq_clr = wdata[IRQ_W-1:0];
  end

  // Sticky flags (set beats clear), enables, and the registered interrupt line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_stat <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~irq_clr) | irq_set;
      if (wr_ok && (waddr == CSR_IRQ_EN) && wstrb[0]) irq_en <= wdata[IRQ_W-1:0];
      irq <= |(irq_stat & irq_en);
    end
  end

  assign unused_in = ^{wdata, wstrb};
`else
  assign irq       = 1'b0;
  assign unused_in = ^{wdata, wstrb, xfer_done_in};
`endif

  // Read address decode
  always_comb begin
    rd_mux = '0;
    case (raddr)
      CSR_CTRL:     rd_mux = ctrl_rd;
      CSR_STAT:     rd_mux = stat_rd;
      CSR_RXDATA:   rd_mux = 32'(rx_head);
`ifdef SPI_CSR_IRQ_EN
      CSR_IRQ_STAT: rd_mux = 32'(irq_stat);
      CSR_IRQ_EN:   rd_mux = 32'(irq_en);
`endif
      default:      rd_mux = '0;
    endcase
  end

  // Registered read response, one cycle after ren
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rdata  <= ren ? rd_mux : '0;
      rvalid <= ren;
    end
  end

endmodule

// File: tb/tb_spi_csr.sv
// tb/tb_spi_csr.sv - directed self-checking bench for spi_csr (either SPI_CSR_IRQ_EN build)
module tb_spi_csr;

`ifdef SPI_CSR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic        wen, wready, ren, rvalid;
  logic [3:0]  wstrb;
  logic        spi_en_out, master_en_out, cpol_out, cpha_out, lsb_first_out;
  logic [7:0]  clk_div_out;
  logic [1:0]  cs_out;
  logic [7:0]  tx_data_out, rx_data_in;
  logic        tx_valid_out, tx_ready_in, rx_valid_in, xfer_done_in, busy_in, irq;

  int total  = 0;
  int passed = 0;

  spi_csr dut (
    .clk(clk), .rst(rst),
    .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
    .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
    .spi_en_out(spi_en_out), .master_en_out(master_en_out), .cpol_out(cpol_out),
    .cpha_out(cpha_out), .lsb_first_out(lsb_first_out), .clk_div_out(clk_div_out),
    .cs_out(cs_out), .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
    .tx_ready_in(tx_ready_in), .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
    .xfer_done_in(xfer_done_in), .busy_in(busy_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // All tasks start and end at posedge+1
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ren = 1'b1; raddr = a;
    @(posedge clk); #1;
    ren = 1'b0;
    check(tag, rdata, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] drain [4];

  initial begin
    rst = 1'b0; wen = 1'b0; ren = 1'b0; waddr = '0; wdata = '0; wstrb = '0; raddr = '0;
    tx_ready_in = 1'b0; rx_data_in = '0; rx_valid_in = 1'b0; xfer_done_in = 1'b0; busy_in = 1'b0;
    drain[0] = 8'h12; drain[1] = 8'h13; drain[2] = 8'h14; drain[3] = 8'h15;

    // Reset values
    tick(3);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_tx_valid", tx_valid_out, 0);
    check("rst_tx_data", tx_data_out, 0);
    check("rst_irq", irq, 0);
    check("rst_cs_div", {cs_out, clk_div_out}, 0);
    rst = 1'b1;
    tick(1);

    // STAT after reset, with read latency
    ren = 1'b1; raddr = 32'h04;
    #1 check("rvalid_before_edge", rvalid, 0);
    @(posedge clk); #1;
    ren = 1'b0;
    check("rvalid_after_ren", rvalid, 1);
    check("stat_reset", rdata, 32'h0000_000A);
    tick(1);
    check("rvalid_drop", rvalid, 0);

    // CTRL fields and byte strobes
    wr(32'h00, 32'h0002_0A1F, 4'hF);
    check("ctrl_bits_out", {lsb_first_out, cpha_out, cpol_out, master_en_out, spi_en_out}, 5'h1F);
    check("clk_div_out", clk_div_out, 8'h0A);
    check("cs_out", cs_out, 2'd2);
    wr(32'h00, 32'h0001_FF00, 4'b0010);
    rd_chk("ctrl_strb", 32'h00, 32'h0002_FF1F);
    wr(32'h00, 32'h0, 4'hF);

    // TX backpressure
    for (int i = 0; i < 4; i++) begin
      wr(32'h08, 32'h11 + i, 4'h0);
      if (i == 0) check("tx_first_head", {tx_valid_out, tx_data_out}, 9'h111);
    end
    rd_chk("stat_tx_full", 32'h04, 32'h0000_0409);
    wen = 1'b1; waddr = 32'h08; wdata = 32'h15;
    #1 check("wready_full", wready, 0);
    tx_ready_in = 1'b1;
    @(posedge clk); #1;
    tx_ready_in = 1'b0;
    check("wready_after_pop", wready, 1);
    @(posedge clk); #1;
    wen = 1'b0;
    check("tx_head_after_pop", tx_data_out, 8'h12);
    rd_chk("tx_level_4", 32'h04, 32'h0000_0409);

    // Drain TX in order
    tx_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tx_drain", {tx_valid_out, tx_data_out}, {1'b1, drain[i]});
      tick(1);
    end
    tx_ready_in = 1'b0;
    check("tx_empty_valid", {tx_valid_out, tx_data_out}, 9'h000);
    check("irq_masked", irq, 0);
    rd_chk("irq_tx_empty_ev", 32'h10, IRQ_ON ? 32'h4 : 32'h0);
    wr(32'h10, 32'h4, 4'hF);
    rd_chk("irq_tx_empty_clr", 32'h10, 32'h0);

    // RX overflow
    wr(32'h14, 32'h2, 4'hF);
    rd_chk("irq_en_rb", 32'h14, IRQ_ON ? 32'h2 : 32'h0);
    for (int i = 0; i < 5; i++) begin
      rx_valid_in = 1'b1; rx_data_in = 8'hA0 + 8'(i);
      tick(1);
    end
    rx_valid_in = 1'b0;
    tick(1);
    check("irq_ovf", irq, IRQ_ON ? 1 : 0);
    rd_chk("stat_rx_full", 32'h04, 32'h0004_0006);
    rd_chk("irq_stat_ovf", 32'h10, IRQ_ON ? 32'h2 : 32'h0);
    for (int i = 0; i < 4; i++) rd_chk("rxdata", 32'h0C, 32'hA0 + i);
    rd_chk("rxdata_empty", 32'h0C, 32'h0);
    wr(32'h10, 32'h2, 4'hF);
    tick(1);
    check("irq_cleared", irq, 0);

    // ren held two cycles pops two words
    for (int i = 0; i < 2; i++) begin
      rx_valid_in = 1'b1; rx_data_in = 8'hB1 + 8'(i);
      tick(1);
    end
    rx_valid_in = 1'b0;
    ren = 1'b1; raddr = 32'h0C;
    tick(1);
    check("rx_burst0", rdata, 32'hB1);
    tick(1);
    ren = 1'b0;
    check("rx_burst1", rdata, 32'hB2);
    rd_chk("stat_rx_drained", 32'h04, 32'h0000_000A);

    // DONE set, then set/clear collision
    xfer_done_in = 1'b1;
    tick(1);
    xfer_done_in = 1'b0;
    rd_chk("irq_done", 32'h10, IRQ_ON ? 32'h1 : 32'h0);
    xfer_done_in = 1'b1;
    wr(32'h10, 32'h1, 4'hF);
    xfer_done_in = 1'b0;
    rd_chk("irq_set_wins", 32'h10, IRQ_ON ? 32'h1 : 32'h0);
    wr(32'h10, 32'h1, 4'hF);
    rd_chk("irq_done_clr", 32'h10, 32'h0);

    // TX flush
    for (int i = 0; i < 3; i++) wr(32'h08, 32'h31 + i, 4'hF);
    rd_chk("stat_tx3", 32'h04, 32'h0000_0308);
    wr(32'h00, 32'h21, 4'hF);
    check("flush_valid", tx_valid_out, 0);
    check("flush_spi_en", spi_en_out, 1);
    rd_chk("stat_flushed", 32'h04, 32'h0000_000A);
    rd_chk("ctrl_flush_rb", 32'h00, 32'h0000_0001);
    rd_chk("flush_no_ev", 32'h10, 32'h0);

    // Unmapped and write-only addresses
    wr(32'h20, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped", 32'h20, 32'h0);
    rd_chk("txdata_read", 32'h08, 32'h0);

    // BUSY lags busy_in by one cycle
    busy_in = 1'b1;
    rd_chk("busy_lag", 32'h04, 32'h0000_000A);
    rd_chk("busy_set", 32'h04, 32'h0000_001A);
    busy_in = 1'b0;

    // Reset mid-operation discards FIFO contents and CTRL
    wr(32'h08, 32'h55, 4'hF);
    wr(32'h08, 32'h66, 4'hF);
    rst = 1'b0;
    #1;
    check("midrst_valid", tx_valid_out, 0);
    check("midrst_spi_en", spi_en_out, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rd_chk("midrst_stat", 32'h04, 32'h0000_000A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
